// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared constants, state encoding and rotate helper for the MAC path
package mac_pkg;

  localparam int WORD_W = 32;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_OUT   = 2'd2;

  // Circular left rotate; a rotate of 0 returns x unchanged because x >> 32 is zero.
  function automatic logic [WORD_W-1:0] rotl32(input logic [WORD_W-1:0] x, input logic [4:0] r);
    logic [5:0] rsh;
    rsh = 6'd32 - {1'b0, r};
    return (x << r) | (x >> rsh);
  endfunction

endpackage

// File: rtl/mac_fold_round.sv
// rtl/mac_fold_round.sv - one combinational keyed fold: rotl(acc ^ d, ROT) + k
module mac_fold_round
  import mac_pkg::*;
#(
  parameter int ROT = 5
) (
  input  logic [31:0] acc,
  input  logic [31:0] d,
  input  logic [31:0] k,
  output logic [31:0] next_acc
);

  localparam logic [4:0] ROT5 = 5'(ROT);

  // Pure datapath; wraps modulo 2^32 naturally through the 32-bit sum.
  always_comb begin
    next_acc = rotl32(acc ^ d, ROT5) + k;
  end

endmodule

// File: rtl/mac_tag_accumulator.sv
// rtl/mac_tag_accumulator.sv - folds a word stream into a keyed MAC and emits tag plus length
module mac_tag_accumulator
  import mac_pkg::*;
#(
  parameter int          ROT       = 5,
  parameter logic [31:0] IV        = 32'h0,
  parameter int          MAX_WORDS = 256
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic [31:0]                  key,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  in_data,
  input  logic                         in_last,
  output logic                         tag_valid,
  input  logic                         tag_ready,
  output logic [31:0]                  tag_data,
  output logic [$clog2(MAX_WORDS):0]   tag_len,
  output logic                         tag_err
);

  localparam int             CW      = $clog2(MAX_WORDS) + 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(MAX_WORDS - 1);

  logic [1:0]    state;
  logic [31:0]   acc;
  logic [31:0]   kreg;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic [31:0]   next_acc;
  logic [31:0]   cnt_next_ext;
  logic          beat;
  logic          final_beat;

  mac_fold_round #(.ROT(ROT)) u_fold (
    .acc      (acc),
    .d        (in_data),
    .k        (kreg),
    .next_acc (next_acc)
  );

  // Beat qualification and the length value that a final beat would publish.
  always_comb begin
    beat         = in_valid & in_ready;
    cnt_next     = cnt + 1'b1;
    cnt_next_ext = {{(32-CW){1'b0}}, cnt_next};
    final_beat   = in_last | (cnt == CNT_MAX);
  end

  // Message FSM and all registered outputs; truncation at MAX_WORDS ends the message with tag_err set.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      acc       <= '0;
      kreg      <= '0;
      cnt       <= '0;
      in_ready  <= 1'b0;
      tag_valid <= 1'b0;
      tag_data  <= '0;
      tag_len   <= '0;
      tag_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            kreg     <= key;
            acc      <= key ^ IV;
            cnt      <= '0;
            in_ready <= 1'b1;
            state    <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (beat) begin
            acc <= next_acc;
            cnt <= cnt_next;
            if (final_beat) begin
              tag_data  <= next_acc ^ cnt_next_ext;
              tag_len   <= cnt_next;
              tag_err   <= ~in_last;
              tag_valid <= 1'b1;
              in_ready  <= 1'b0;
              state     <= S_OUT;
            end
          end
        end
        S_OUT: begin
          if (tag_ready) begin
            tag_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          in_ready  <= 1'b0;
          tag_valid <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_tag_accumulator.sv
// tb/tb_mac_tag_accumulator.sv - directed self-checking bench for mac_tag_accumulator
module tb_mac_tag_accumulator;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [31:0] key;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        tag_valid;
  logic        tag_ready;
  logic [31:0] tag_data;
  logic [2:0]  tag_len;
  logic        tag_err;

  int errors;
  int checks;

  mac_tag_accumulator #(.ROT(5), .IV(32'h0), .MAX_WORDS(4)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .key       (key),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .tag_valid (tag_valid),
    .tag_ready (tag_ready),
    .tag_data  (tag_data),
    .tag_len   (tag_len),
    .tag_err   (tag_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_tag(input string tag, input logic [31:0] d, input logic [31:0] l, input logic e);
    chk({tag, "_valid"}, {31'd0, tag_valid}, 32'd1);
    chk({tag, "_data"}, tag_data, d);
    chk({tag, "_len"}, {29'd0, tag_len}, l);
    chk({tag, "_err"}, {31'd0, tag_err}, {31'd0, e});
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    reset_n   = 1'b0;
    start     = 1'b0;
    key       = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    tag_ready = 1'b0;

    repeat (2) @(posedge clock);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_tag_valid", {31'd0, tag_valid}, 32'd0);
    chk("rst_tag_data", tag_data, 32'd0);
    chk("rst_tag_len", {29'd0, tag_len}, 32'd0);
    chk("rst_tag_err", {31'd0, tag_err}, 32'd0);
    reset_n = 1'b1;
    in_valid = 1'b1;
    step();
    chk("idle_ignores_valid", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;

    // Case 1: key 0, single word 1.
    start = 1'b1; key = 32'h0;
    step();
    start = 1'b0;
    chk("c1_in_ready_after_start", {31'd0, in_ready}, 32'd1);
    chk("c1_no_tag_yet", {31'd0, tag_valid}, 32'd0);
    in_valid = 1'b1; in_data = 32'h1; in_last = 1'b1;
    step();
    in_valid = 1'b0; in_last = 1'b0;
    chk_tag("c1", 32'h0000_0021, 32'd1, 1'b0);
    tag_ready = 1'b1;
    step();
    tag_ready = 1'b0;
    chk("c1_released", {31'd0, tag_valid}, 32'd0);

    // Case 2 with backpressure: key 1, words 1 then 2.
    start = 1'b1; key = 32'h1;
    step();
    start = 1'b0;
    in_valid = 1'b1; in_data = 32'h1; in_last = 1'b0;
    step();
    chk("c2_mid_in_ready", {31'd0, in_ready}, 32'd1);
    chk("c2_mid_no_tag", {31'd0, tag_valid}, 32'd0);
    in_data = 32'h2; in_last = 1'b1;
    step();
    in_last = 1'b0;
    chk_tag("c2", 32'h0000_0063, 32'd2, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("c4_hold_valid", {31'd0, tag_valid}, 32'd1);
      chk("c4_hold_data", tag_data, 32'h0000_0063);
      chk("c4_hold_len", {29'd0, tag_len}, 32'd2);
      chk("c4_hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    tag_ready = 1'b1; start = 1'b1;
    step();
    tag_ready = 1'b0; start = 1'b0;
    chk("c4_idle_after_ready", {31'd0, tag_valid}, 32'd0);
    chk("c4_start_at_handshake_ignored", {31'd0, in_ready}, 32'd0);
    step();
    chk("c4_still_idle", {31'd0, in_ready}, 32'd0);

    // Case 3: rotate wrap of bit 31 into bit 4.
    start = 1'b1; key = 32'h0;
    step();
    start = 1'b0;
    in_valid = 1'b1; in_data = 32'h8000_0000; in_last = 1'b1;
    step();
    in_valid = 1'b0; in_last = 1'b0;
    chk_tag("c3", 32'h0000_0011, 32'd1, 1'b0);
    tag_ready = 1'b1;
    step();
    tag_ready = 1'b0;

    // Case 5: four words without last truncate at MAX_WORDS=4.
    start = 1'b1; key = 32'h0;
    step();
    start = 1'b0;
    in_valid = 1'b1; in_last = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      in_data = i;
      step();
    end
    in_data = 32'h5;
    chk_tag("c5", 32'h0011_0C84, 32'd4, 1'b1);
    step();
    chk("c5_fifth_not_taken_len", {29'd0, tag_len}, 32'd4);
    chk("c5_fifth_not_taken_data", tag_data, 32'h0011_0C84);
    chk("c5_fifth_in_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    tag_ready = 1'b1;
    step();
    tag_ready = 1'b0;
    chk("c5_released", {31'd0, tag_valid}, 32'd0);

    // Case 6: reset after two of three words aborts the message.
    start = 1'b1; key = 32'h1;
    step();
    start = 1'b0;
    in_valid = 1'b1; in_data = 32'h1;
    step();
    in_data = 32'h2;
    step();
    in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("c6_async_in_ready", {31'd0, in_ready}, 32'd0);
    chk("c6_async_tag_valid", {31'd0, tag_valid}, 32'd0);
    chk("c6_async_tag_data", tag_data, 32'd0);
    chk("c6_async_tag_len", {29'd0, tag_len}, 32'd0);
    step();
    reset_n = 1'b1;
    in_valid = 1'b1; in_data = 32'h3; in_last = 1'b1;
    step();
    in_valid = 1'b0; in_last = 1'b0;
    chk("c6_no_tag", {31'd0, tag_valid}, 32'd0);
    chk("c6_idle", {31'd0, in_ready}, 32'd0);
    start = 1'b1; key = 32'h1;
    step();
    start = 1'b0;
    in_valid = 1'b1; in_data = 32'h1; in_last = 1'b0;
    step();
    in_data = 32'h2; in_last = 1'b1;
    step();
    in_valid = 1'b0; in_last = 1'b0;
    chk_tag("c6_fresh", 32'h0000_0063, 32'd2, 1'b0);
    tag_ready = 1'b1;
    step();
    tag_ready = 1'b0;
    chk("c6_released", {31'd0, tag_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
